// File: rtl/seq_demux_deserializer.sv
// Serial-to-parallel word assembler: steers accepted bits into lanes 0..N-1 in order
// and presents each completed word on a valid/ready output with a one-word holding register.
module seq_demux_deserializer #(
    parameter  int N     = 4,
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     number,
    output logic [SEL_W-1:0] cur_sel
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N-1:0]     acc_q, acc_d;
    logic [N-1:0]     number_q, number_d;
    logic             valid_q, valid_d;
    logic             accept;
    logic             complete;

    // Only the word-completing bit can stall, and only against an undrained full output.
    assign in_ready = !flush && ((sel_q != LAST) || !valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign complete = accept && (sel_q == LAST);

    always_comb begin
        sel_d    = sel_q;
        acc_d    = acc_q;
        number_d = number_q;
        valid_d  = valid_q;

        if (flush) begin
            sel_d = '0;
            acc_d = '0;
        end else if (accept) begin
            acc_d[sel_q] = in_bit;
            if (complete) begin
                sel_d    = '0;
                acc_d    = '0;
                number_d = {in_bit, acc_q[N-2:0]};
            end else begin
                sel_d = sel_q + SEL_W'(1);
            end
        end

        // A completion in the same cycle as a drain simply replaces the word.
        if (complete) begin
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q    <= '0;
            acc_q    <= '0;
            number_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            sel_q    <= sel_d;
            acc_q    <= acc_d;
            number_q <= number_d;
            valid_q  <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign number    = number_q;
    assign cur_sel   = sel_q;

endmodule

// File: tb/tb_seq_demux_deserializer.sv
// Bench for seq_demux_deserializer: directed per-cycle vector table, async-reset corner,
// and a randomized run against a queue-based word model with an output scoreboard.
module tb_seq_demux_deserializer;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_bit, in_ready, flush;
    logic       out_valid, out_ready;
    logic [3:0] number;
    logic [1:0] cur_sel;

    int n_cmp  = 0;
    int n_fail = 0;

    seq_demux_deserializer #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .number    (number),
        .cur_sel   (cur_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic b, input logic fl, input logic ordy);
        in_valid  = iv;
        in_bit    = b;
        flush     = fl;
        out_ready = ordy;
    endtask

    // Apply inputs for one cycle and advance to just after the next rising edge.
    task automatic cyc(input logic iv, input logic b, input logic fl, input logic ordy);
        drive(iv, b, fl, ordy);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       iv, b, fl, ordy;
        logic       e_ir;
        logic [1:0] e_sel;
        logic       e_ov;
        logic [3:0] e_num;
    } vec_t;

    vec_t tbl[37];

    // Behavioural model state for the random phase
    int   partial[$];
    int   words_q[$];
    logic m_ov;
    int   m_num;

    initial begin
        // inputs, then expected in_ready / cur_sel / out_valid / number seen during that cycle
        tbl[0]  = '{1,1,0,1, 1,2'd0,0,4'b0000};
        tbl[1]  = '{1,0,0,1, 1,2'd1,0,4'b0000};
        tbl[2]  = '{1,1,0,1, 1,2'd2,0,4'b0000};
        tbl[3]  = '{1,1,0,1, 1,2'd3,0,4'b0000};
        tbl[4]  = '{0,0,0,1, 1,2'd0,1,4'b1101};
        tbl[5]  = '{0,0,0,1, 1,2'd0,0,4'b1101};
        tbl[6]  = '{1,1,0,1, 1,2'd0,0,4'b1101};
        tbl[7]  = '{1,1,0,1, 1,2'd1,0,4'b1101};
        tbl[8]  = '{1,0,0,1, 1,2'd2,0,4'b1101};
        tbl[9]  = '{1,0,0,1, 1,2'd3,0,4'b1101};
        tbl[10] = '{1,0,0,1, 1,2'd0,1,4'b0011};
        tbl[11] = '{1,1,0,1, 1,2'd1,0,4'b0011};
        tbl[12] = '{1,0,0,1, 1,2'd2,0,4'b0011};
        tbl[13] = '{1,1,0,1, 1,2'd3,0,4'b0011};
        tbl[14] = '{0,0,0,0, 1,2'd0,1,4'b1010};
        tbl[15] = '{0,0,0,1, 1,2'd0,1,4'b1010};
        tbl[16] = '{1,1,0,0, 1,2'd0,0,4'b1010};
        tbl[17] = '{1,1,0,0, 1,2'd1,0,4'b1010};
        tbl[18] = '{1,1,0,0, 1,2'd2,0,4'b1010};
        tbl[19] = '{1,1,0,0, 1,2'd3,0,4'b1010};
        tbl[20] = '{1,0,0,0, 1,2'd0,1,4'b1111};
        tbl[21] = '{1,1,0,0, 1,2'd1,1,4'b1111};
        tbl[22] = '{1,1,0,0, 1,2'd2,1,4'b1111};
        tbl[23] = '{1,1,0,0, 0,2'd3,1,4'b1111};
        tbl[24] = '{1,1,0,0, 0,2'd3,1,4'b1111};
        tbl[25] = '{1,0,0,1, 1,2'd3,1,4'b1111};
        tbl[26] = '{0,0,0,1, 1,2'd0,1,4'b0110};
        tbl[27] = '{0,0,0,0, 1,2'd0,0,4'b0110};
        tbl[28] = '{1,1,0,1, 1,2'd0,0,4'b0110};
        tbl[29] = '{1,1,0,1, 1,2'd1,0,4'b0110};
        tbl[30] = '{1,1,1,1, 0,2'd2,0,4'b0110};
        tbl[31] = '{1,0,0,1, 1,2'd0,0,4'b0110};
        tbl[32] = '{1,1,0,1, 1,2'd1,0,4'b0110};
        tbl[33] = '{1,0,0,1, 1,2'd2,0,4'b0110};
        tbl[34] = '{1,0,0,1, 1,2'd3,0,4'b0110};
        tbl[35] = '{0,0,0,1, 1,2'd0,1,4'b0010};
        tbl[36] = '{0,0,0,0, 1,2'd0,0,4'b0010};

        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_number",    32'(number),    0);
        check("reset_cur_sel",   32'(cur_sel),   0);
        check("reset_in_ready",  32'(in_ready),  1);
        $display("reset: out_valid=%0b number=%b cur_sel=%0d in_ready=%0b", out_valid, number, cur_sel, in_ready);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 37; i++) begin
            drive(tbl[i].iv, tbl[i].b, tbl[i].fl, tbl[i].ordy);
            @(negedge clk);
            $display("vec %0d: iv=%0b bit=%0b flush=%0b ordy=%0b -> in_ready=%0b cur_sel=%0d out_valid=%0b number=%b",
                     i, tbl[i].iv, tbl[i].b, tbl[i].fl, tbl[i].ordy, in_ready, cur_sel, out_valid, number);
            check($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].e_ir));
            check($sformatf("vec%0d_cur_sel", i),   32'(cur_sel),   32'(tbl[i].e_sel));
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            check($sformatf("vec%0d_number", i),    32'(number),    32'(tbl[i].e_num));
            @(posedge clk);
            #1;
        end

        // Asynchronous reset mid-word while a word is pending
        cyc(1, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0); cyc(1, 1, 0, 0);
        drive(0, 0, 0, 0);
        check("pre_arst_cur_sel",   32'(cur_sel),   2);
        check("pre_arst_out_valid", 32'(out_valid), 1);
        check("pre_arst_number",    32'(number),    32'b1101);
        #1 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_number",    32'(number),    0);
        check("arst_cur_sel",   32'(cur_sel),   0);
        check("arst_in_ready",  32'(in_ready),  1);
        $display("async reset mid-word: out_valid=%0b number=%b cur_sel=%0d", out_valid, number, cur_sel);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized run against the word model
        begin
            int   n_done = 0;
            int   n_rcv  = 0;
            int   cycles = 0;
            logic iv, b, fl, ordy, e_ir, acc, cpl, old_ov;
            int   w;
            partial.delete();
            words_q.delete();
            m_ov  = 1'b0;
            m_num = 0;
            while (n_done < 1000 && cycles < 60000) begin
                iv   = ($urandom_range(0, 3) != 0);
                b    = 1'($urandom);
                fl   = ($urandom_range(0, 49) == 0);
                ordy = ($urandom_range(0, 2) != 0);
                drive(iv, b, fl, ordy);
                @(negedge clk);
                e_ir = !fl && (partial.size() != N - 1 || !m_ov || ordy);
                check("rnd_in_ready",  32'(in_ready),  32'(e_ir));
                check("rnd_cur_sel",   32'(cur_sel),   32'(partial.size()));
                check("rnd_out_valid", 32'(out_valid), 32'(m_ov));
                check("rnd_number",    32'(number),    32'(m_num));
                if (out_valid && out_ready) begin
                    if (words_q.size() == 0) begin
                        check("rnd_unexpected_word", 32'(number), 32'hFFFF_FFFF);
                    end else begin
                        w = words_q.pop_front();
                        check("rnd_scoreboard", 32'(number), 32'(w));
                        $display("word %0d: number=%b expected=%b", n_rcv, number, 4'(w));
                    end
                    n_rcv++;
                end
                acc    = iv && e_ir;
                cpl    = acc && (partial.size() == N - 1);
                old_ov = m_ov;
                if (fl) begin
                    partial.delete();
                end else if (acc) begin
                    partial.push_back(int'(b));
                    if (cpl) begin
                        w = 0;
                        foreach (partial[k]) w += partial[k] << k;
                        m_num = w;
                        m_ov  = 1'b1;
                        words_q.push_back(w);
                        partial.delete();
                        n_done++;
                    end
                end
                if (old_ov && ordy && !cpl) m_ov = 1'b0;
                @(posedge clk);
                #1;
                cycles++;
            end
            check("rnd_word_budget", 32'(n_done >= 1000), 1);
            check("rnd_word_count",  32'(n_rcv + (m_ov ? 1 : 0)), 32'(n_done));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_demux_deserializer.md
Name: seq_demux_deserializer

Overview:
- Inverse of the team's 4:1 bit-select mux: accepts one bit per handshake and steers it into the output word lane given by an internal selector (lane 0 first, matching mux mapping selection=00 -> number[0]).
- A free-running lane counter replaces the external selection input. Once all lanes are filled, the block presents the assembled word on a valid/ready output.
- Sits at the receive end of the serialised bit path that the mux drives.

Parameters:
- N, 4, number of lanes (output word width); N >= 2.
- SEL_W, $clog2(N), width of the lane selector; derived, not overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  in_bit is valid this cycle.
- in_bit  input  1  serial data bit.
- in_ready  output  1  block accepts in_bit this cycle.
- flush  input  1  synchronous abort of the partially assembled word.
- out_valid  output  1  number holds a complete word.
- out_ready  input  1  consumer takes number this cycle.
- number  output  N  assembled word; bit k = k-th accepted bit of the word.
- cur_sel  output  SEL_W  lane the next accepted bit will fill.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - cur_sel=0, accumulator=0, number=0, out_valid=0.
  - in_ready follows its combinational equation, so it is 1 in reset.
  - Any partial word is lost.
- Accept: accept = in_valid && in_ready && !flush.
  - On accept, acc[cur_sel] <= in_bit.
  - If cur_sel < N-1: cur_sel <= cur_sel+1.
  - If cur_sel == N-1: cur_sel <= 0 (wrap), number <= {in_bit, acc[N-2:0]}, out_valid <= 1, acc <= 0.
- Latency: the word is visible on number/out_valid the cycle after the N-th bit is accepted.
- Output hold: while out_valid=1 && out_ready=0, number is stable.
- Output drain: when out_valid && out_ready and no word completes that cycle, out_valid <= 0 and number retains its old value.
- Simultaneous drain and completion: out_valid stays 1 and number takes the new word (zero bubble).
- in_ready (combinational) = !flush && ((cur_sel != N-1) || !out_valid || out_ready).
  - Lanes 0..N-2 are always accepted while an old word waits.
  - Only the completing bit stalls, and only when the output is full and not draining.
- Flush (synchronous, priority over accept):
  - cur_sel <= 0, acc <= 0, in_ready=0 that cycle, in_bit is ignored.
  - number/out_valid are unaffected and the output handshake still proceeds.
- in_bit is don't-care when in_valid=0; cur_sel and acc do not change without accept.
- Bits accepted while an old word is pending never corrupt number until that word is drained.

Test Plan:
- Reset, then bits 1,0,1,1 on 4 consecutive cycles with out_ready=1 -> cur_sel 0,1,2,3,0; out_valid=1 one cycle after the 4th bit with number=4'b1101; cleared the next cycle.
- Two back-to-back words 1,1,0,0 then 0,1,0,1 with out_ready=1 -> in_ready constantly 1; number=4'b0011 then 4'b1010 on consecutive completions with no bubble.
- out_ready=0 after the first word 4'b1111, then feed 3 more bits -> accepted; cur_sel=3; in_ready=0 at lane 3; number holds 4'b1111. Raise out_ready -> 4th bit accepted the same cycle; next cycle number holds the new word.
- Feed 2 bits (1,1), assert flush with in_valid=1 -> in_ready=0, cur_sel=0. Then 0,1,0,0 -> number=4'b0010 (old bits discarded).
- Assert rst_n=0 mid-word (cur_sel=2) while out_valid=1 -> immediately out_valid=0, number=0, cur_sel=0 without waiting for a clock edge.
- Randomised in_valid/out_ready gaps over 1000 words vs a scoreboard -> every word matches its 4 bits LSB-first; no loss or duplication.
